// File: rtl/mdu_pkg.sv
// Shared types for the multiply/divide unit: op encoding, FSM states, divide timing.
// Latency and flow-control behaviour are owned by mul_div_unit; nothing here is clocked.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5,
    MDU_MUL   = 3'd6
  } mdu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV_ITER,
    ST_DIV_FIX
  } mdu_state_t;

  // Accept cycle, 32 iterations, 1 sign-fix/write cycle: result visible 34 cycles after accept.
  localparam int DIV_CYCLES = 34;
  localparam int DIV_ITERS  = DIV_CYCLES - 2;

  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_iter.sv
// Unsigned 32/32 restoring divider core: one quotient bit per step, 32 steps after ld.
// No flow control; the owner sequences ld/step and reads quo/rem once all steps are done.
module div_iter (
  input  logic        clk,
  input  logic        ld,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quo,
  output logic [31:0] rem
);

  // Upper half holds the partial remainder, lower half shifts dividend out and quotient in.
  logic [63:0] pr;
  logic [31:0] dvsr;
  logic [32:0] top;
  logic [31:0] diff;
  logic        fits;

  always_comb begin
    top  = pr[63:31];
    fits = (top >= {1'b0, dvsr});
    diff = top[31:0] - dvsr;
  end

  always_ff @(posedge clk) begin
    if (ld) begin
      pr   <= {32'd0, dividend};
      dvsr <= divisor;
    end else if (step) begin
      pr <= fits ? {diff, pr[30:0], 1'b1} : {top[31:0], pr[30:0], 1'b0};
    end
  end

  assign quo = pr[31:0];
  assign rem = pr[63:32];

endmodule

// File: rtl/mul_div_unit.sv
// HI/LO owner: mult/multu/mul in MUL_CYCLES, div/divu in 34 cycles, mthi/mtlo in 1 cycle.
// busy=1 while an op is in flight; start is ignored while busy or flushed, flush aborts without writing.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int MUL_CYCLES = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  mdu_op_t     op,
  input  logic [31:0] srca,
  input  logic [31:0] srcb,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [4:0] MUL_LAST = 5'(MUL_CYCLES - 1);
  localparam logic [4:0] DIV_LAST = 5'(DIV_ITERS - 1);

  mdu_state_t  state, state_nxt;
  logic [4:0]  cnt, cnt_nxt;
  logic        accept, is_mul_op, is_div_op, is_signed;
  logic [32:0] mul_a, mul_b;
  logic [63:0] prod, prod_q;
  logic        neg_quo_q, neg_rem_q, dvsr_zero_q;
  logic        div_ld, div_step;
  logic [31:0] div_a, div_b, quo_mag, rem_mag, quo_fix, rem_fix;
  logic        wr_en;
  logic [63:0] wr_val;

  assign busy      = (state != ST_IDLE);
  assign accept    = start && !busy && !flush;
  assign is_mul_op = op inside {MDU_MULT, MDU_MULTU, MDU_MUL};
  assign is_div_op = op inside {MDU_DIV, MDU_DIVU};
  assign is_signed = (op != MDU_MULTU) && (op != MDU_DIVU);

  // One signed 33x33 multiplier covers both signednesses via the extension bit.
  assign mul_a = {is_signed & srca[31], srca};
  assign mul_b = {is_signed & srcb[31], srcb};
  assign prod  = 64'($signed(mul_a)) * 64'($signed(mul_b));

  // Magnitudes are taken in the accept cycle so the core is loaded before the first iteration.
  assign div_a  = mag32(srca, is_signed);
  assign div_b  = mag32(srcb, is_signed);
  assign div_ld = accept && is_div_op;

  div_iter u_div_iter (
    .clk      (clk),
    .ld       (div_ld),
    .step     (div_step),
    .dividend (div_a),
    .divisor  (div_b),
    .quo      (quo_mag),
    .rem      (rem_mag)
  );

  // A zero divisor leaves rem_mag = |a|, so only the quotient needs the override.
  assign quo_fix = dvsr_zero_q ? 32'hFFFF_FFFF : (neg_quo_q ? (~quo_mag + 32'd1) : quo_mag);
  assign rem_fix = neg_rem_q ? (~rem_mag + 32'd1) : rem_mag;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wr_en     = 1'b0;
    wr_val    = prod_q;
    div_step  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept && is_mul_op) begin
          state_nxt = ST_MUL;
          cnt_nxt   = 5'd1;
        end else if (accept && is_div_op) begin
          state_nxt = ST_DIV_ITER;
          cnt_nxt   = 5'd0;
        end
      end
      ST_MUL: begin
        if (flush) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = 5'd0;
        end else if (cnt == MUL_LAST) begin
          wr_en     = 1'b1;
          state_nxt = ST_IDLE;
          cnt_nxt   = 5'd0;
        end else begin
          cnt_nxt = cnt + 5'd1;
        end
      end
      ST_DIV_ITER: begin
        if (flush) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = 5'd0;
        end else begin
          div_step = 1'b1;
          if (cnt == DIV_LAST) begin
            state_nxt = ST_DIV_FIX;
            cnt_nxt   = 5'd0;
          end else begin
            cnt_nxt = cnt + 5'd1;
          end
        end
      end
      ST_DIV_FIX: begin
        state_nxt = ST_IDLE;
        if (!flush) begin
          wr_en  = 1'b1;
          wr_val = {rem_fix, quo_fix};
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      cnt         <= 5'd0;
      done        <= 1'b0;
      hi          <= 32'd0;
      lo          <= 32'd0;
      prod_q      <= 64'd0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      dvsr_zero_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      done  <= wr_en;
      if (wr_en) begin
        {hi, lo} <= wr_val;
      end else if (accept && op == MDU_MTHI) begin
        hi <= srca;
      end else if (accept && op == MDU_MTLO) begin
        lo <= srca;
      end
      if (accept) begin
        prod_q      <= prod;
        neg_quo_q   <= is_signed & (srca[31] ^ srcb[31]);
        neg_rem_q   <= is_signed & srca[31];
        dvsr_zero_q <= (srcb == 32'd0);
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Table-driven check of mul_div_unit with a result scoreboard, plus flush/reset/busy corner sequences.
module tb_mul_div_unit;
  import mdu_pkg::*;

  localparam int MUL_CYC = 3;
  localparam int DIV_LAT = 34;
  localparam int NV      = 16;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  mdu_op_t     op = MDU_MULT;
  logic [31:0] srca = 32'd0;
  logic [31:0] srcb = 32'd0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  bit allow_busy_start = 1'b0;
  logic [63:0] sb_q[$];

  typedef struct {
    mdu_op_t     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;
  vec_t vecs[NV];

  always #5 clk = ~clk;

  mul_div_unit #(.MUL_CYCLES(MUL_CYC)) dut (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
    .op     (op),
    .srca   (srca),
    .srcb   (srcb),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  always @(negedge clk)
    assert (!(resetn && start && busy && !allow_busy_start))
      else $error("start driven while busy");

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input mdu_op_t o, input logic [31:0] a, input logic [31:0] b);
    longint p;
    int     sa, sb;
    case (o)
      MDU_MULT, MDU_MUL: begin
        p = longint'($signed(a)) * longint'($signed(b));
        return p;
      end
      MDU_MULTU: return {32'd0, a} * {32'd0, b};
      MDU_DIVU: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      MDU_DIV: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        sa = a;
        sb = b;
        return {32'(sa % sb), 32'(sa / sb)};
      end
      default: return 64'd0;
    endcase
  endfunction

  task automatic issue(input mdu_op_t o, input logic [31:0] a, input logic [31:0] b);
    op   = o;
    srca = a;
    srcb = b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Entered lat0 cycles after the accept cycle; returns the cycle offset where done was seen.
  task automatic wait_done(input int lat0, output int lat, output int gaps, output bit seen);
    lat  = lat0;
    gaps = 0;
    seen = 1'b0;
    while (!seen && lat <= 100) begin
      if (done) seen = 1'b1;
      else begin
        if (!busy) gaps++;
        tick();
        lat++;
      end
    end
  endtask

  task automatic check_result(input string name, input int lat0, input int exp_lat);
    int lat, gaps;
    bit seen;
    logic [63:0] exp;
    wait_done(lat0, lat, gaps, seen);
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: done not seen, required at cycle %0d", name, exp_lat);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
    end else begin
      exp = sb_q.pop_front();
      chk({name, "_result"}, {hi, lo}, exp);
      chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
      chk({name, "_busy_gap"}, 64'(gaps), 64'd0);
      chk({name, "_busy_at_done"}, 64'(busy), 64'd0);
      tick();
      chk({name, "_done_pulse"}, 64'(done), 64'd0);
    end
  endtask

  initial begin
    mdu_op_t     pool[5];
    mdu_op_t     o;
    logic [31:0] a, b;
    logic [63:0] m;
    int          dn;

    pool = '{MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MUL};
    vecs[0] = '{MDU_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[1] = '{MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2] = '{MDU_MUL,   32'd6,         32'd7,         32'd0,         32'd42};
    vecs[3] = '{MDU_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[4] = '{MDU_DIVU,  32'd7,         32'd2,         32'd1,         32'd3};
    vecs[5] = '{MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
    vecs[6] = '{MDU_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF};
    vecs[7] = '{MDU_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
    vecs[8] = '{MDU_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF};
    vecs[9] = '{MDU_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    for (int i = 10; i < NV; i++) begin
      o = pool[$urandom_range(4)];
      a = $urandom;
      b = (i == NV - 1) ? 32'($urandom_range(9)) : $urandom;
      m = model(o, a, b);
      vecs[i] = '{o, a, b, m[63:32], m[31:0]};
    end

    // Reset state
    repeat (3) tick();
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);
    resetn = 1'b1;
    tick();

    // Table: every mult/div op through the scoreboard
    for (int i = 0; i < NV; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      sb_q.push_back({vecs[i].hi, vecs[i].lo});
      check_result($sformatf("vec%0d", i),
                   1, (vecs[i].op inside {MDU_DIV, MDU_DIVU}) ? DIV_LAT : MUL_CYC);
    end

    // MTHI visible next cycle, LO untouched, never busy
    issue(MDU_MTLO, 32'h0000_CAFE, 32'd0);
    issue(MDU_MTHI, 32'h1234_5678, 32'd0);
    chk("mthi_hi", 64'(hi), 64'h1234_5678);
    chk("mthi_lo", 64'(lo), 64'h0000_CAFE);
    chk("mthi_busy", 64'(busy), 64'd0);
    chk("mthi_done", 64'(done), 64'd0);

    // Flush mid-divide: no write, no done
    issue(MDU_MTHI, 32'h11, 32'd0);
    issue(MDU_MTLO, 32'h22, 32'd0);
    issue(MDU_DIV, 32'd100, 32'd7);
    repeat (9) tick();
    chk("flush_busy_before", 64'(busy), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy_after", 64'(busy), 64'd0);
    chk("flush_hilo", {hi, lo}, {32'h11, 32'h22});
    dn = 0;
    repeat (40) begin
      if (done) dn++;
      tick();
    end
    chk("flush_no_done", 64'(dn), 64'd0);
    chk("flush_hilo_late", {hi, lo}, {32'h11, 32'h22});

    // start while busy is ignored
    issue(MDU_DIVU, 32'd7, 32'd2);
    sb_q.push_back(model(MDU_DIVU, 32'd7, 32'd2));
    tick();
    tick();
    allow_busy_start = 1'b1;
    op    = MDU_MTHI;
    srca  = 32'h0000_DEAD;
    start = 1'b1;
    tick();
    start = 1'b0;
    allow_busy_start = 1'b0;
    check_result("busy_start", 4, DIV_LAT);

    // flush together with start: nothing accepted
    op    = MDU_MTLO;
    srca  = 32'h0000_BEEF;
    start = 1'b1;
    flush = 1'b1;
    tick();
    op    = MDU_MULT;
    srca  = 32'd3;
    srcb  = 32'd3;
    tick();
    start = 1'b0;
    flush = 1'b0;
    chk("flush_start_lo", 64'(lo), 64'd3);
    chk("flush_start_busy", 64'(busy), 64'd0);

    // flush in the write cycle of a multiply
    issue(MDU_MULT, 32'd5, 32'd5);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_last_done", 64'(done), 64'd0);
    chk("flush_last_hilo", {hi, lo}, {32'd1, 32'd3});
    chk("flush_last_busy", 64'(busy), 64'd0);

    // reset in the middle of a divide
    issue(MDU_DIV, 32'd100, 32'd7);
    repeat (4) tick();
    resetn = 1'b0;
    tick();
    chk("midreset_hilo", {hi, lo}, 64'd0);
    chk("midreset_busy", 64'(busy), 64'd0);
    chk("midreset_done", 64'(done), 64'd0);
    resetn = 1'b1;
    repeat (2) tick();

    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
